// File: rtl/divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at accept time without iterating.
module divider_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             flush,
    input  logic [1:0]       div_opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result_divide,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_answer;
    logic [CW-1:0]    r_count;
    logic             r_opSigned;
    logic             r_opRem;
    logic             r_neg1;
    logic             r_neg2;
    logic             r_done;

    logic             w_isSigned;
    logic             w_isRem;
    logic             w_divByZero;
    logic             w_overflow;
    logic             w_special;
    logic             w_accept;
    logic             w_lastIter;
    logic [WIDTH-1:0] w_absOp1;
    logic [WIDTH-1:0] w_absOp2;
    logic [WIDTH-1:0] w_specialResult;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_trialOk;
    logic [WIDTH-1:0] w_nextRem;
    logic [WIDTH-1:0] w_fixedQuo;
    logic [WIDTH-1:0] w_fixedRem;

    always_comb begin
        w_isSigned      = ~div_opcode[0];
        w_isRem         = div_opcode[1];
        w_divByZero     = (operand2 == '0);
        w_overflow      = w_isSigned && (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (operand2 == '1);
        w_special       = w_divByZero || w_overflow;
        w_accept        = (r_state == IDLE) && startE && !flush;
        w_lastIter      = (r_count == CW'(WIDTH - 1));
        w_absOp1        = (w_isSigned && operand1[WIDTH-1]) ? -operand1 : operand1;
        w_absOp2        = (w_isSigned && operand2[WIDTH-1]) ? -operand2 : operand2;
        w_specialResult = '0;
        if (w_divByZero) begin
            w_specialResult = w_isRem ? operand1 : '1;
        end else if (!w_isRem) begin
            w_specialResult = operand1;
        end
    end

    // Remainder stays below the divisor, so bit WIDTH of the difference is a reliable sign.
    always_comb begin
        w_shifted  = {r_rem, r_quo[WIDTH-1]};
        w_diff     = w_shifted - {1'b0, r_divisor};
        w_trialOk  = ~w_diff[WIDTH];
        w_nextRem  = w_trialOk ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
        w_fixedQuo = (r_opSigned && (r_neg1 != r_neg2)) ? -r_quo : r_quo;
        w_fixedRem = (r_opSigned && r_neg1) ? -r_rem : r_rem;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush && (r_state != IDLE)) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_nextState = w_special ? DONE : BUSY;
                BUSY:    if (w_lastIter) w_nextState = FIX;
                FIX:     w_nextState = DONE;
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // The result is committed only on leaving DONE, so a flush anywhere leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_quo         <= '0;
            r_rem         <= '0;
            r_divisor     <= '0;
            r_answer      <= '0;
            r_count       <= '0;
            r_opSigned    <= 1'b0;
            r_opRem       <= 1'b0;
            r_neg1        <= 1'b0;
            r_neg2        <= 1'b0;
            r_done        <= 1'b0;
            result_divide <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opSigned <= w_isSigned;
                        r_opRem    <= w_isRem;
                        r_neg1     <= w_isSigned && operand1[WIDTH-1];
                        r_neg2     <= w_isSigned && operand2[WIDTH-1];
                        r_quo      <= w_absOp1;
                        r_divisor  <= w_absOp2;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_answer   <= w_specialResult;
                    end
                end
                BUSY: begin
                    r_rem   <= w_nextRem;
                    r_quo   <= {r_quo[WIDTH-2:0], w_trialOk};
                    r_count <= r_count + CW'(1);
                end
                FIX: begin
                    r_answer <= r_opRem ? w_fixedRem : w_fixedQuo;
                end
                DONE: begin
                    if (!flush) begin
                        result_divide <= r_answer;
                        r_done        <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        done = r_done;
        busy = (r_state != IDLE);
    end

endmodule

// File: tb/tb_divider_iterative.sv
// Directed bench for divider_iterative: results, done/busy timing, reset and flush aborts.
module tb_divider_iterative;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        startE;
    logic        flush;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result_divide;
    logic        done;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    divider_iterative #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .startE        (startE),
        .flush         (flush),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_opcode = op;
        operand1   = a;
        operand2   = b;
        startE     = 1'b1;
    endtask

    // Accept edge is edge 0; latency is the edge count after which done is first seen high.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expResult,
                         input int expLatency, input bit holdStart);
        int n;
        int busyCount;
        bit seen;
        applyStimulus(op, a, b);
        @(posedge clk); #1;
        if (!holdStart) startE = 1'b0;
        busyCount = busy ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                operand1 = 32'd1;
                operand2 = 32'd1;
            end
            if (done) seen = 1'b1;
            else if (busy) busyCount++;
        end
        startE = 1'b0;
        checkOutput({tag, " latency"}, 32'(n), 32'(expLatency));
        checkOutput({tag, " result"}, result_divide, expResult);
        checkOutput({tag, " busy cycles"}, 32'(busyCount), 32'(expLatency));
        @(posedge clk); #1;
        checkOutput({tag, " done pulse width"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idle after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit doneSeen;
        rst        = 1'b0;
        startE     = 1'b0;
        flush      = 1'b0;
        div_opcode = OP_DIV;
        operand1   = '0;
        operand2   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result_divide, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        runOp("DIV -7/2",        OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
        runOp("REM -7/2",        OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
        runOp("REMU F9/2",       OP_REMU, 32'hFFFF_FFF9, 32'd2,         32'd1,         34, 1'b0);
        runOp("DIVU FF/16",      OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34, 1'b0);
        runOp("DIV 7/-2",        OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        runOp("REM 7/-2",        OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34, 1'b0);
        runOp("DIV 5/0",         OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        runOp("REMU 5/0",        OP_REMU, 32'd5,         32'd0,         32'd5,         1,  1'b0);
        runOp("DIV overflow",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        runOp("REM overflow",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
        runOp("DIVU held start", OP_DIVU, 32'd100,       32'd7,         32'd14,        34, 1'b1);

        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1;
        startE = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midop reset busy", {31'd0, busy}, 32'd0);
        checkOutput("midop reset done", {31'd0, done}, 32'd0);
        checkOutput("midop reset result", result_divide, 32'd0);
        rst = 1'b1;
        doneSeen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("midop reset no done", {31'd0, doneSeen}, 32'd0);
        runOp("DIV 9/3", OP_DIV, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        runOp("DIVU seed", OP_DIVU, 32'h1234_5678, 32'd1, 32'h1234_5678, 34, 1'b0);
        applyStimulus(OP_REM, 32'd50, 32'd7);
        @(posedge clk); #1;
        startE = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush busy", {31'd0, busy}, 32'd0);
        checkOutput("flush done", {31'd0, done}, 32'd0);
        checkOutput("flush result held", result_divide, 32'h1234_5678);
        runOp("REM 50/7 reissue", OP_REM, 32'd50, 32'd7, 32'd1, 34, 1'b0);

        flush = 1'b1;
        applyStimulus(OP_DIV, 32'd9, 32'd3);
        @(posedge clk); #1;
        startE = 1'b0;
        flush  = 1'b0;
        checkOutput("flush blocks start", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("flush blocks done", {31'd0, done}, 32'd0);
        checkOutput("flush blocks result", result_divide, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage.
- Sits directly downstream of the M-extension controller, which supplies operand1/operand2/div_opcode and the start strobe.
- Produces a 32-bit quotient or remainder with a registered one-cycle done pulse.
- Replaces the single-cycle combinational divider; the controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits; the RV32 configuration is 32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk
- startE  input  1  start strobe from the execute stage; sampled only in IDLE
- flush  input  1  synchronous abort from hazard/flush logic
- div_opcode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with startE
- operand1  input  WIDTH  dividend; sampled with startE
- operand2  input  WIDTH  divisor; sampled with startE
- result_divide  output  WIDTH  quotient or remainder; registered
- done  output  1  one-cycle pulse; result_divide is valid in that cycle
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; result_divide=0; done=0; busy=0; iteration counter=0; internal registers=0. Reset takes priority over flush and startE and aborts any operation in progress.
- States: IDLE, BUSY, FIX, DONE.
- Accept: when state=IDLE and startE=1 at an edge, latch opcode and both operand signs. For signed ops (DIV, REM), latch abs(operand1) and abs(operand2); for DIVU/REMU, latch raw values. Clear the remainder register and set counter=0.
- Special cases are resolved at the accept edge and skip iteration (IDLE->DONE directly):
  - operand2==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand1.
  - DIV/REM with operand1=0x80000000 and operand2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Otherwise IDLE->BUSY.
- BUSY, one quotient bit per cycle:
  - Shift {rem,quo} left by 1, then trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set quo[0]=1; otherwise restore and set quo[0]=0.
  - After exactly WIDTH iterations (counter 0..WIDTH-1), go BUSY->FIX.
- FIX:
  - Quotient is negated when signed and sign(op1)!=sign(op2).
  - Remainder is negated when signed and op1 was negative.
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU) into result_divide. FIX->DONE.
- DONE: done=1 for exactly one cycle. DONE->IDLE unconditionally. startE is not accepted in DONE.
- Latency, with the accept edge as edge 0:
  - Normal op: done high between edge WIDTH+2 and edge WIDTH+3 (34 and 35 for WIDTH=32).
  - Special case: done high between edge 1 and edge 2.
- Earliest next accept is the edge ending the done cycle (state is IDLE after it), i.e. edge 35 for a normal op, giving a back-to-back issue interval of 35 cycles.
- result_divide holds its last value after done until the next result is written or rst=0. It is not cleared on return to IDLE.
- startE in BUSY, FIX or DONE is ignored; no queueing.
- flush=1 at an edge in any non-IDLE state: go to IDLE; done stays 0 and result_divide keeps its previous value.
- flush=1 together with startE=1 in IDLE: the start is not accepted.
- The controller drives operand1/operand2/div_opcode continuously. After acceptance the block uses only its latched copies, so input changes mid-operation have no effect.
- No combinational path from any input to any output; all outputs are registered or decoded from state only.

Test Plan:
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> result 0xFFFFFFFD (-3); done pulses exactly 34 cycles after the accept edge; busy high for 34 cycles.
- REM -7,2 -> 0xFFFFFFFF. REMU 0xFFFFFFF9,2 -> 1. DIVU 0xFFFFFFFF,0x10 -> 0x0FFFFFFF.
- Divide-by-zero, DIV 5,0 -> 0xFFFFFFFF and REMU 5,0 -> 5; overflow, DIV 0x80000000,0xFFFFFFFF -> 0x80000000 and REM -> 0. Each special case pulses done 1 cycle after accept.
- startE held high throughout a DIVU 100,7: only one accept; result 14; operands changed to 1,1 mid-operation do not change the result.
- rst=0 at cycle 10 of a DIV: next cycle busy=0, done=0, result_divide=0; no done pulse follows; a new DIV 9,3 then returns 3.
- flush at cycle 20 of a REM 50,7 (previous result 0x12345678): busy drops the next cycle, no done pulse, result_divide stays 0x12345678; an immediate re-issue returns 1.
